axi4l_counter_peripheral: RTL and testbench

Memory-mapped 32-bit up-counter behind an AXI4-Lite slave port. Software programs a start value, enables and disables counting, and reads back the live count. It sits on the system peripheral bus as a timing/profiling aid. A single FSM services one transaction at a time.

---
 rtl/axi4l_counter_peripheral_pkg.sv | 26 ++
 rtl/axi4l_counter_peripheral_if.sv | 24 ++
 rtl/axi4l_counter_peripheral_counter_core.sv | 21 ++
 rtl/axi4l_counter_peripheral.sv | 113 +++++++++++
 tb/tb_axi4l_counter_peripheral.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4l_counter_peripheral_pkg.sv
// Shared constants, response codes and FSM state type for the AXI4-Lite counter peripheral.
// COUNTER_OVF_EN (optional) adds the STATUS register and ovf_irq.
package counter_pkg;

  localparam logic [7:0] CTRL_OFF   = 8'h00;
  localparam logic [7:0] COUNT_OFF  = 8'h04;
  localparam logic [7:0] INIT_OFF   = 8'h08;
  localparam logic [7:0] STATUS_OFF = 8'h0C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_e;

  // Merge write data into a register one byte lane at a time.
  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/axi4l_counter_peripheral_if.sv
// AXI4-Lite bus bundle for the counter peripheral (32-bit address/data).
interface axi4l_counter_peripheral_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_counter_peripheral_counter_core.sv
// 32-bit free-running count register with load strobe and wrap pulse.
module counter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] init_val,
  output logic [31:0] count,
  output logic        wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= init_val;
    else if (en)   count <= count + 32'd1;
  end

  // Pulses in the cycle whose edge takes count from all-ones to zero.
  assign wrap = en && !load && (count == '1);

endmodule

// File: rtl/axi4l_counter_peripheral.sv
// AXI4-Lite slave exposing CTRL / COUNT / INIT_VAL (and STATUS with COUNTER_OVF_EN).
// One transaction in flight; writes win over reads offered in the same cycle.
module axi4l_counter_peripheral
  import counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  axi4l_counter_peripheral_if.slave s
`ifdef COUNTER_OVF_EN
  , output logic ovf_irq
`endif
);

  state_e      state, state_nxt;
  logic        wr_acc, rd_acc, load, wrap, enable, w_hit, r_hit;
  logic [31:0] init_val, count, rd_val;
  logic [7:0]  waddr, raddr;
  logic        unused_bits;

  assign waddr  = s.awaddr[7:0];
  assign raddr  = s.araddr[7:0];
  assign wr_acc = (state == IDLE) && s.awvalid && s.wvalid;
  assign rd_acc = (state == IDLE) && s.arvalid && !(s.awvalid && s.wvalid);
  // Only a 0->1 transition of enable reloads the count.
  assign load   = wr_acc && (waddr == CTRL_OFF) && s.wstrb[0] && s.wdata[0] && !enable;

`ifdef COUNTER_OVF_EN
  logic ovf_flag;
  assign w_hit = waddr inside {CTRL_OFF, INIT_OFF, STATUS_OFF};
  assign r_hit = raddr inside {CTRL_OFF, COUNT_OFF, INIT_OFF, STATUS_OFF};
  assign ovf_irq = ovf_flag;
  assign unused_bits = ^{s.awaddr[31:8], s.araddr[31:8]};

  // Wrap beats a same-cycle W1C so an overflow is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_flag <= 1'b0;
    else if (wrap) ovf_flag <= 1'b1;
    else if (wr_acc && waddr == STATUS_OFF && s.wstrb[0] && s.wdata[0]) ovf_flag <= 1'b0;
  end
`else
  assign w_hit = waddr inside {CTRL_OFF, INIT_OFF};
  assign r_hit = raddr inside {CTRL_OFF, COUNT_OFF, INIT_OFF};
  assign unused_bits = ^{s.awaddr[31:8], s.araddr[31:8], wrap};
`endif

  counter_core u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (enable),
    .load     (load),
    .init_val (init_val),
    .count    (count),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_acc) state_nxt = WRESP;
               else if (rd_acc) state_nxt = RRESP;
      WRESP:   if (s.bready) state_nxt = IDLE;
      RRESP:   if (s.rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.awready = wr_acc;
    s.wready  = wr_acc;
    s.arready = rd_acc;
    s.bvalid  = (state == WRESP);
    s.rvalid  = (state == RRESP);
  end

  always_comb begin
    rd_val = '0;
    case (raddr)
      CTRL_OFF:   rd_val = {31'b0, enable};
      COUNT_OFF:  rd_val = count;
      INIT_OFF:   rd_val = init_val;
`ifdef COUNTER_OVF_EN
      STATUS_OFF: rd_val = {31'b0, ovf_flag};
`endif
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable   <= 1'b0;
      init_val <= '0;
      s.bresp  <= RESP_OKAY;
      s.rresp  <= RESP_OKAY;
      s.rdata  <= '0;
    end else begin
      if (wr_acc) begin
        s.bresp <= w_hit ? RESP_OKAY : RESP_SLVERR;
        if (waddr == CTRL_OFF && s.wstrb[0]) enable <= s.wdata[0];
        if (waddr == INIT_OFF) init_val <= apply_strb(init_val, s.wdata, s.wstrb);
      end
      if (rd_acc) begin
        s.rdata <= rd_val;
        s.rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4l_counter_peripheral.sv
// Randomized + directed bench for axi4l_counter_peripheral against a time-based count model.
// Build with +define+COUNTER_OVF_EN to cover STATUS / ovf_irq.
module tb_axi4l_counter_peripheral;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4l_counter_peripheral_if bus();
`ifdef COUNTER_OVF_EN
  logic ovf_irq;
`endif

  axi4l_counter_peripheral dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
`ifdef COUNTER_OVF_EN
    , .ovf_irq (ovf_irq)
`endif
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscmp  = 0;

  // Reference model: count is an affine function of the edge index while enabled.
  bit          m_en;
  logic [31:0] m_init, m_base, m_frozen;
  longint      m_bcyc, m_clr;
  bit          m_sticky;

  function automatic logic [31:0] cnt_after(input longint n);
    return m_en ? m_base + 32'(n - m_bcyc) : m_frozen;
  endfunction

  function automatic bit flag_after(input longint n);
    longint we;
    we = m_bcyc + 64'h1_0000_0000 - {32'h0, m_base};
    return m_sticky || (m_en && we >= m_clr && we <= n);
  endfunction

  function automatic bit mapped(input logic [7:0] o, input bit is_rd);
    bit ovf = 1'b0;
`ifdef COUNTER_OVF_EN
    ovf = 1'b1;
`endif
    return (o == 8'h00) || (o == 8'h08) || (is_rd && o == 8'h04) || (ovf && o == 8'h0C);
  endfunction

  task automatic model_reset();
    m_en = 0; m_init = '0; m_base = '0; m_frozen = '0;
    m_bcyc = cyc; m_clr = 0; m_sticky = 0;
  endtask

  task automatic model_write(input logic [7:0] o, input logic [31:0] d,
                             input logic [3:0] st, input longint a);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    if (o == 8'h00 && st[0]) begin
      if (d[0] && !m_en) begin
        m_base = m_init; m_bcyc = a; m_en = 1;
      end else if (!d[0] && m_en) begin
        m_sticky = flag_after(a); m_frozen = cnt_after(a); m_en = 0;
      end
    end
    if (o == 8'h08) m_init = (m_init & ~mask) | (d & mask);
`ifdef COUNTER_OVF_EN
    if (o == 8'h0C && st[0] && d[0]) begin
      m_sticky = 0; m_clr = a;
    end
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit with_ar, input bit hold,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1; bus.wvalid = 1;
    if (with_ar) begin bus.arvalid = 1; bus.araddr = 32'h0000_0004; end
    #1;
    if (with_ar) chk("wr_prio_arready", 32'(bus.arready), 0);
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge clk); #1; n++; end
    chk("aw_accept", 32'(bus.awready && bus.wready), 1);
    @(posedge clk); #1;
    model_write(addr[7:0], data, strb, cyc);
    bus.arvalid = 0;
    if (hold) begin
      chk("no_double_accept", 32'(bus.awready), 0);
      @(posedge clk); #1;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bvalid_latency", n, 0);
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 0;
    chk("bvalid_drop", 32'(bus.bvalid), 0);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output longint acc);
    int n;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); #1; n++; end
    chk("ar_accept", 32'(bus.arready), 1);
    @(posedge clk); #1;
    acc = cyc;
    bus.arvalid = 0; bus.rready = 1;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rvalid_latency", n, 0);
    data = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 0;
    chk("rvalid_drop", 32'(bus.rvalid), 0);
  endtask

  task automatic wr_chk(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input string tag, input bit with_ar = 0, input bit hold = 0);
    logic [1:0] r;
    bus_write(addr, data, strb, with_ar, hold, r);
    chk({tag, "_bresp"}, 32'(r), 32'(mapped(addr[7:0], 0) ? RESP_OKAY : RESP_SLVERR));
  endtask

  task automatic rd_chk(input logic [31:0] addr, input string tag, output logic [31:0] d,
                        output longint a);
    logic [1:0]  r;
    logic [31:0] e;
    bus_read(addr, d, r, a);
    case (addr[7:0])
      8'h00:   e = {31'b0, m_en};
      8'h04:   e = cnt_after(a - 1);
      8'h08:   e = m_init;
`ifdef COUNTER_OVF_EN
      8'h0C:   e = {31'b0, flag_after(a - 1)};
`endif
      default: e = '0;
    endcase
    chk({tag, "_rresp"}, 32'(r), 32'(mapped(addr[7:0], 1) ? RESP_OKAY : RESP_SLVERR));
    chk({tag, "_rdata"}, d, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d1, d2, rnd;
    longint      a1, a2;
    logic [7:0]  offs [8];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h01, 8'h06, 8'hFC};

    {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} = '0;
    bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.araddr = '0;
    model_reset();

    #2;
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_ready",  32'({bus.awready, bus.wready, bus.arready}), 0);
    chk("rst_resp",   32'({bus.bresp, bus.rresp}), 0);
    chk("rst_rdata",  bus.rdata, 0);
`ifdef COUNTER_OVF_EN
    chk("rst_ovf_irq", 32'(ovf_irq), 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    model_reset();

    // Directed bring-up
    wr_chk(32'h08, 32'h0000_1000, 4'hF, "init_wr");
    rd_chk(32'h08, "init_rd", d1, a1);
    wr_chk(32'h00, 32'h1, 4'hF, "en_wr");
    idle(5);
    rd_chk(32'h04, "cnt_rd1", d1, a1);
    idle(5);
    rd_chk(32'h04, "cnt_rd2", d2, a2);
    chk("cnt_delta", d2 - d1, 32'(a2 - a1));
    wr_chk(32'h00, 32'h0, 4'hF, "dis_wr");
    rd_chk(32'h04, "hold_rd1", d1, a1);
    idle(5);
    rd_chk(32'h04, "hold_rd2", d2, a2);
    chk("hold_equal", d2, d1);
    wr_chk(32'h00, 32'h1, 4'hF, "reen_wr");
    wr_chk(32'h00, 32'h1, 4'hF, "en_again_wr", 0, 1);
    idle(3);
    rd_chk(32'h04, "reload_rd", d1, a1);
    rd_chk(32'h10, "unmap_rd", d1, a1);
    wr_chk(32'h04, 32'h5, 4'hF, "count_wr");
    rd_chk(32'h04, "count_after_wr", d1, a1);
    wr_chk(32'h08, 32'hDEAD_BEEF, 4'b0101, "init_strb", 1, 0);
    rd_chk(32'h08, "init_strb_rd", d1, a1);
    rd_chk(32'hABCD_EF0C, "status_or_unmap", d1, a1);

    // Random mix of mapped/unmapped, byte-strobed and enable-toggling traffic
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom;
      case ($urandom_range(0, 4))
        0: wr_chk({rnd[31:8], 8'h08}, $urandom, 4'($urandom_range(0, 15)), "r_init");
        1: wr_chk({rnd[31:8], 8'h00}, $urandom, 4'($urandom_range(0, 15)), "r_ctrl",
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        2: rd_chk({rnd[31:8], offs[$urandom_range(0, 7)]}, "r_rd", d1, a1);
        3: rd_chk({rnd[31:8], 8'h04}, "r_cnt", d1, a1);
        default: wr_chk({rnd[31:8], offs[$urandom_range(1, 7)]}, $urandom, 4'hF, "r_wr");
      endcase
      idle($urandom_range(0, 4));
    end

`ifdef COUNTER_OVF_EN
    wr_chk(32'h00, 32'h0, 4'hF, "ovf_dis");
    wr_chk(32'h0C, 32'h1, 4'hF, "ovf_preclr");
    chk("ovf_irq_pre", 32'(ovf_irq), 32'(flag_after(cyc)));
    wr_chk(32'h08, 32'hFFFF_FFFE, 4'hF, "ovf_init");
    wr_chk(32'h00, 32'h1, 4'hF, "ovf_en");
    idle(3);
    chk("ovf_irq_set", 32'(ovf_irq), 32'(flag_after(cyc)));
    chk("ovf_irq_high", 32'(ovf_irq), 1);
    rd_chk(32'h0C, "ovf_status", d1, a1);
    wr_chk(32'h0C, 32'h1, 4'hF, "ovf_w1c");
    rd_chk(32'h0C, "ovf_status_clr", d1, a1);
    chk("ovf_irq_clr", 32'(ovf_irq), 0);
`endif

    // Reset during an outstanding read response
    @(negedge clk);
    bus.araddr = 32'h04; bus.arvalid = 1;
    @(posedge clk); #1;
    bus.arvalid = 0;
    chk("mid_rvalid", 32'(bus.rvalid), 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_rvalid", 32'(bus.rvalid), 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    model_reset();
    @(negedge clk); rst = 0;
    rd_chk(32'h00, "post_rst_ctrl", d1, a1);
    rd_chk(32'h04, "post_rst_cnt", d1, a1);
    rd_chk(32'h08, "post_rst_init", d1, a1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
